// File: rtl/csi_tx_pkt_sched.sv
// -----------------------------------------------------------------------------
// csi_tx_pkt_sched
// Packet sequencer for the CSI-2 TX core. Converts pix2byte frame/line events
// into FS/FE short packets and RAW10 long packets, requests the HS clock/data
// lanes, and tracks the long-packet payload byte count.
//
// Optional feature macro: CSI_FRAME_NUM_EN
//   defined   -> wc_o carries a 16-bit frame number on FS/FE (1 after reset,
//                wraps 0xFFFF -> 0x0001, advances on every FE packet)
//   undefined -> wc_o is 0 on FS/FE and no frame counter is built
//
// Ports
//   hf_clk90      clock, all inputs synchronous to it
//   reset_n_byte  asynchronous active-low reset
//   fv_start_i / fv_end_i / lv_start_i / lv_end_i   1-cycle event pulses
//   byte_en_i     payload byte strobe (one byte per high cycle)
//   c2d_ready_i   TX core ready for a packet
//   d_hs_rdy_i    HS lane ready
//   err_clr_i     clears the sticky error bits
//   hs_en_o       HS lane request
//   sp_en_o       short packet strobe (1 cycle)
//   lp_en_o       long packet header strobe (1 cycle)
//   dt_o, wc_o    packet data type / word count (or frame number)
//   busy_o        sequencer is not resting in IDLE or FRAME
//   line_cnt_o    completed lines in the current frame
//   err_o         sticky: [0] ready timeout, [1] lv outside frame,
//                 [2] byte/line count mismatch, [3] event dropped
//   state_o       current FSM state, for debug visibility
//
// Handshake: a packet is launched only when c2d_ready_i and d_hs_rdy_i are
// both high in the same cycle while a *_REQ state holds hs_en_o; the matching
// sp_en_o/lp_en_o strobe follows one cycle later.
// -----------------------------------------------------------------------------
module csi_tx_pkt_sched #(
    parameter logic [15:0] WC_LINE     = 16'd800,
    parameter logic [5:0]  DT_PIXEL    = 6'h2B,
    parameter logic [15:0] LINES       = 16'd2,
    parameter logic [9:0]  RDY_TIMEOUT = 10'd1023
) (
    input  logic        hf_clk90,
    input  logic        reset_n_byte,
    input  logic        fv_start_i,
    input  logic        fv_end_i,
    input  logic        lv_start_i,
    input  logic        lv_end_i,
    input  logic        byte_en_i,
    input  logic        c2d_ready_i,
    input  logic        d_hs_rdy_i,
    input  logic        err_clr_i,
    output logic        hs_en_o,
    output logic        sp_en_o,
    output logic        lp_en_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic        busy_o,
    output logic [15:0] line_cnt_o,
    output logic [3:0]  err_o,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FS_REQ  = 4'd1,
        S_FS_PKT  = 4'd2,
        S_FRAME   = 4'd3,
        S_LP_REQ  = 4'd4,
        S_LP_PKT  = 4'd5,
        S_LP_DATA = 4'd6,
        S_FE_REQ  = 4'd7,
        S_FE_PKT  = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_to_cnt;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_line_cnt;
    logic [5:0]  r_dt;
    logic [15:0] r_wc;
    logic [3:0]  r_err;
    logic        r_fe_pend;
    logic        r_line_open;

    logic        w_rdy;
    logic        w_is_req;
    logic        w_timeout;
    logic        w_last_byte;
    logic [15:0] w_fnum;
    logic [3:0]  w_err_set;
    logic        w_set_pend;
    logic        w_clr_pend;
    logic        w_load;
    logic [5:0]  w_load_dt;
    logic [15:0] w_load_wc;
    logic        w_line_inc;

    assign w_rdy       = c2d_ready_i && d_hs_rdy_i;
    assign w_is_req    = (r_state == S_FS_REQ) || (r_state == S_LP_REQ) || (r_state == S_FE_REQ);
    // Fires on the RDY_TIMEOUT-th consecutive cycle spent in a *_REQ state.
    assign w_timeout   = w_is_req && !w_rdy && (r_to_cnt == RDY_TIMEOUT - 10'd1);
    // The byte that brings the payload count up to WC_LINE closes the line.
    assign w_last_byte = byte_en_i && (r_byte_cnt == WC_LINE - 16'd1);

`ifdef CSI_FRAME_NUM_EN
    logic [15:0] r_frame_num;

    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            r_frame_num <= 16'd1;
        end else if (r_state == S_FE_PKT) begin
            // Zero is skipped so a valid frame number is never 0.
            r_frame_num <= (r_frame_num == 16'hFFFF) ? 16'd1 : r_frame_num + 16'd1;
        end
    end

    assign w_fnum = r_frame_num;
`else
    assign w_fnum = 16'd0;
`endif

    // Next-state and event decode.
    always_comb begin
        w_next     = r_state;
        w_err_set  = 4'b0000;
        w_set_pend = 1'b0;
        w_clr_pend = 1'b0;
        w_load     = 1'b0;
        w_load_dt  = 6'h00;
        w_load_wc  = 16'd0;
        w_line_inc = 1'b0;

        // A new frame can only start from IDLE.
        if (fv_start_i && (r_state != S_IDLE)) w_err_set[3] = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (fv_start_i) w_next = S_FS_REQ;
                if (lv_start_i) w_err_set[1] = 1'b1;
                if (fv_end_i)   w_err_set[3] = 1'b1;
            end
            S_FS_REQ: begin
                if (w_rdy) begin
                    w_next    = S_FS_PKT;
                    w_load    = 1'b1;
                    w_load_dt = 6'h00;
                    w_load_wc = w_fnum;
                end else if (w_timeout) begin
                    w_next       = S_IDLE;
                    w_err_set[0] = 1'b1;
                end
                if (lv_start_i) w_err_set[1] = 1'b1;
                if (fv_end_i)   w_err_set[3] = 1'b1;
            end
            S_FS_PKT: begin
                w_next = S_FRAME;
                if (lv_start_i) w_err_set[1] = 1'b1;
                if (fv_end_i)   w_err_set[3] = 1'b1;
            end
            S_FRAME: begin
                // A pending or fresh frame end takes priority over a new line.
                if (r_fe_pend || fv_end_i) begin
                    w_next     = S_FE_REQ;
                    w_clr_pend = 1'b1;
                    if (lv_start_i) w_err_set[3] = 1'b1;
                end else if (lv_start_i) begin
                    w_next = S_LP_REQ;
                end
                // Bytes arriving after the line already delivered WC_LINE.
                if (byte_en_i && r_line_open) w_err_set[2] = 1'b1;
            end
            S_LP_REQ: begin
                if (w_rdy) begin
                    w_next    = S_LP_PKT;
                    w_load    = 1'b1;
                    w_load_dt = DT_PIXEL;
                    w_load_wc = WC_LINE;
                end else if (w_timeout) begin
                    w_next       = S_FRAME;
                    w_err_set[0] = 1'b1;
                end
                if (lv_start_i) w_err_set[3] = 1'b1;
                if (fv_end_i)   w_set_pend   = 1'b1;
            end
            S_LP_PKT: begin
                w_next = S_LP_DATA;
                if (lv_start_i) w_err_set[3] = 1'b1;
                if (fv_end_i)   w_set_pend   = 1'b1;
            end
            S_LP_DATA: begin
                if (w_last_byte) begin
                    w_next     = S_FRAME;
                    w_line_inc = 1'b1;
                end else if (lv_end_i) begin
                    w_next       = S_FRAME;
                    w_err_set[2] = 1'b1;
                end
                if (lv_start_i) w_err_set[3] = 1'b1;
                if (fv_end_i)   w_set_pend   = 1'b1;
            end
            S_FE_REQ: begin
                if (w_rdy) begin
                    w_next    = S_FE_PKT;
                    w_load    = 1'b1;
                    w_load_dt = 6'h01;
                    w_load_wc = w_fnum;
                end else if (w_timeout) begin
                    w_next       = S_FRAME;
                    w_err_set[0] = 1'b1;
                end
                if (lv_start_i) w_err_set[1] = 1'b1;
                if (fv_end_i)   w_err_set[3] = 1'b1;
            end
            S_FE_PKT: begin
                w_next = S_IDLE;
                if (r_line_cnt != LINES) w_err_set[2] = 1'b1;
                if (lv_start_i) w_err_set[1] = 1'b1;
                if (fv_end_i)   w_err_set[3] = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= 10'd0;
            r_byte_cnt  <= 16'd0;
            r_line_cnt  <= 16'd0;
            r_dt        <= 6'h00;
            r_wc        <= 16'd0;
            r_err       <= 4'b0000;
            r_fe_pend   <= 1'b0;
            r_line_open <= 1'b0;
        end else begin
            r_state <= w_next;

            // Counter restarts on every state change, so each REQ visit gets a full budget.
            if (w_is_req && (w_next == r_state)) r_to_cnt <= r_to_cnt + 10'd1;
            else                                 r_to_cnt <= 10'd0;

            if (r_state == S_LP_PKT)
                r_byte_cnt <= 16'd0;
            else if ((r_state == S_LP_DATA) && byte_en_i && (r_byte_cnt != WC_LINE))
                r_byte_cnt <= r_byte_cnt + 16'd1;

            if (r_state == S_FS_PKT)  r_line_cnt <= 16'd0;
            else if (w_line_inc)      r_line_cnt <= r_line_cnt + 16'd1;

            // dt/wc hold from PKT entry until the next packet is launched.
            if (w_load) begin
                r_dt <= w_load_dt;
                r_wc <= w_load_wc;
            end

            // Sticky errors: a new set outranks a simultaneous clear.
            r_err <= (err_clr_i ? 4'b0000 : r_err) | w_err_set;

            if (w_set_pend)      r_fe_pend <= 1'b1;
            else if (w_clr_pend) r_fe_pend <= 1'b0;

            // Line stays open from its header until lv_end, to catch trailing bytes.
            if (r_state == S_LP_PKT)      r_line_open <= 1'b1;
            else if (lv_end_i)            r_line_open <= 1'b0;
            else if (r_state == S_FS_PKT) r_line_open <= 1'b0;
        end
    end

    // Strobes and lane request decode straight from the state register, so an
    // asynchronous reset drops them immediately.
    assign hs_en_o    = (r_state != S_IDLE) && (r_state != S_FRAME);
    assign busy_o     = (r_state != S_IDLE) && (r_state != S_FRAME);
    assign sp_en_o    = (r_state == S_FS_PKT) || (r_state == S_FE_PKT);
    assign lp_en_o    = (r_state == S_LP_PKT);
    assign dt_o       = r_dt;
    assign wc_o       = r_wc;
    assign line_cnt_o = r_line_cnt;
    assign err_o      = r_err;
    assign state_o    = r_state;

endmodule

// File: tb/tb_csi_tx_pkt_sched.sv
module tb_csi_tx_pkt_sched;

    logic        hf_clk90;
    logic        reset_n_byte;
    logic        fv_start_i, fv_end_i, lv_start_i, lv_end_i, byte_en_i;
    logic        c2d_ready_i, d_hs_rdy_i, err_clr_i;
    logic        hs_en_o, sp_en_o, lp_en_o, busy_o;
    logic [5:0]  dt_o;
    logic [15:0] wc_o, line_cnt_o;
    logic [3:0]  err_o, state_o;

`ifdef CSI_FRAME_NUM_EN
    localparam bit FNUM_EN = 1'b1;
`else
    localparam bit FNUM_EN = 1'b0;
`endif

    // Expected packets: {lp, dt[5:0], wc[15:0]}
    logic [22:0] exp_q[$];
    logic [15:0] exp_fnum;
    int          n_asserts;
    int          n_fail;

    csi_tx_pkt_sched dut (
        .hf_clk90     (hf_clk90),
        .reset_n_byte (reset_n_byte),
        .fv_start_i   (fv_start_i),
        .fv_end_i     (fv_end_i),
        .lv_start_i   (lv_start_i),
        .lv_end_i     (lv_end_i),
        .byte_en_i    (byte_en_i),
        .c2d_ready_i  (c2d_ready_i),
        .d_hs_rdy_i   (d_hs_rdy_i),
        .err_clr_i    (err_clr_i),
        .hs_en_o      (hs_en_o),
        .sp_en_o      (sp_en_o),
        .lp_en_o      (lp_en_o),
        .dt_o         (dt_o),
        .wc_o         (wc_o),
        .busy_o       (busy_o),
        .line_cnt_o   (line_cnt_o),
        .err_o        (err_o),
        .state_o      (state_o)
    );

    // ---------------- clock / watchdog ----------------
    initial hf_clk90 = 1'b0;
    always #5 hf_clk90 = ~hf_clk90;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every packet strobe must match the oldest expected packet.
    always @(negedge hf_clk90) begin
        if (reset_n_byte && (sp_en_o || lp_en_o)) begin
            if (exp_q.size() == 0) begin
                check("pkt_unexpected", 32'd0, 32'd1);
            end else begin
                check("pkt", {9'd0, lp_en_o, dt_o, wc_o}, {9'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge hf_clk90);
        #1;
    endtask

    function automatic logic [15:0] fs_fe_wc();
        return FNUM_EN ? exp_fnum : 16'd0;
    endfunction

    task automatic start_frame();
        exp_q.push_back({1'b0, 6'h00, fs_fe_wc()});
        fv_start_i = 1'b1;
        tick(1);
        fv_start_i = 1'b0;
        tick(3);
    endtask

    task automatic push_fe();
        exp_q.push_back({1'b0, 6'h01, fs_fe_wc()});
        exp_fnum = (exp_fnum == 16'hFFFF) ? 16'd1 : exp_fnum + 16'd1;
    endtask

    task automatic end_frame();
        push_fe();
        fv_end_i = 1'b1;
        tick(1);
        fv_end_i = 1'b0;
        tick(4);
    endtask

    // n payload bytes; lv_end either with the last byte or one cycle after.
    task automatic send_line(input int n, input bit end_on_last, input bit fv_too);
        exp_q.push_back({1'b1, 6'h2B, 16'd800});
        lv_start_i = 1'b1;
        tick(1);
        lv_start_i = 1'b0;
        tick(2);
        for (int i = 0; i < n; i++) begin
            byte_en_i = 1'b1;
            if (end_on_last && (i == n - 1)) begin
                lv_end_i = 1'b1;
                if (fv_too) begin
                    push_fe();
                    fv_end_i = 1'b1;
                end
            end
            tick(1);
        end
        byte_en_i = 1'b0;
        lv_end_i  = 1'b0;
        fv_end_i  = 1'b0;
        if (!end_on_last) begin
            lv_end_i = 1'b1;
            tick(1);
            lv_end_i = 1'b0;
        end
        tick(1);
    endtask

    task automatic pulse_err_clr();
        err_clr_i = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hs_cycles;
        n_asserts    = 0;
        n_fail       = 0;
        exp_fnum     = 16'd1;
        reset_n_byte = 1'b0;
        fv_start_i   = 1'b0;
        fv_end_i     = 1'b0;
        lv_start_i   = 1'b0;
        lv_end_i     = 1'b0;
        byte_en_i    = 1'b0;
        c2d_ready_i  = 1'b1;
        d_hs_rdy_i   = 1'b1;
        err_clr_i    = 1'b0;
        tick(3);

        check("rst_hs_en", {31'd0, hs_en_o}, 32'd0);
        check("rst_sp_en", {31'd0, sp_en_o}, 32'd0);
        check("rst_lp_en", {31'd0, lp_en_o}, 32'd0);
        check("rst_dt", {26'd0, dt_o}, 32'd0);
        check("rst_wc", {16'd0, wc_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_line_cnt", {16'd0, line_cnt_o}, 32'd0);
        check("rst_err", {28'd0, err_o}, 32'd0);
        reset_n_byte = 1'b1;
        tick(2);

        // Normal frame with two full lines.
        start_frame();
        check("t1_line0", {16'd0, line_cnt_o}, 32'd0);
        send_line(800, 1'b0, 1'b0);
        check("t1_line1", {16'd0, line_cnt_o}, 32'd1);
        send_line(800, 1'b0, 1'b0);
        check("t1_line2", {16'd0, line_cnt_o}, 32'd2);
        end_frame();
        check("t1_err", {28'd0, err_o}, 32'd0);
        check("t1_line_end", {16'd0, line_cnt_o}, 32'd2);
        check("t1_hs_off", {31'd0, hs_en_o}, 32'd0);
        check("t1_q_empty", exp_q.size(), 32'd0);

        // Ready held low: timeout after 1023 request cycles, back to IDLE.
        c2d_ready_i = 1'b0;
        fv_start_i  = 1'b1;
        tick(1);
        fv_start_i = 1'b0;
        hs_cycles  = 0;
        for (int i = 0; i < 1100; i++) begin
            if (hs_en_o) hs_cycles++;
            tick(1);
        end
        check("t2_hs_cycles", hs_cycles, 32'd1023);
        check("t2_err", {28'd0, err_o}, 32'd1);
        check("t2_hs_off", {31'd0, hs_en_o}, 32'd0);
        check("t2_busy", {31'd0, busy_o}, 32'd0);
        c2d_ready_i = 1'b1;
        // In IDLE an lv_start is an out-of-frame error and requests nothing.
        lv_start_i = 1'b1;
        tick(1);
        lv_start_i = 1'b0;
        hs_cycles  = 0;
        for (int i = 0; i < 5; i++) begin
            if (hs_en_o) hs_cycles++;
            tick(1);
        end
        check("t2_lv_idle_hs", hs_cycles, 32'd0);
        check("t2_lv_idle_err", {28'd0, err_o}, 32'd3);
        pulse_err_clr();
        check("t2_err_clr", {28'd0, err_o}, 32'd0);

        // fv_end together with lv_end on the final byte: line closes, then FE.
        start_frame();
        send_line(800, 1'b0, 1'b0);
        send_line(800, 1'b1, 1'b1);
        tick(4);
        check("t3_err", {28'd0, err_o}, 32'd0);
        check("t3_line_cnt", {16'd0, line_cnt_o}, 32'd2);
        check("t3_q_empty", exp_q.size(), 32'd0);

        // Short line, dropped fv_start, then recovery.
        start_frame();
        fv_start_i = 1'b1;
        tick(1);
        fv_start_i = 1'b0;
        tick(1);
        check("t4_fv_in_frame", {28'd0, err_o}, 32'd8);
        pulse_err_clr();
        send_line(500, 1'b0, 1'b0);
        check("t4_short_err", {28'd0, err_o}, 32'd4);
        check("t4_short_line_cnt", {16'd0, line_cnt_o}, 32'd0);
        pulse_err_clr();
        check("t4_err_clr", {28'd0, err_o}, 32'd0);
        send_line(800, 1'b0, 1'b0);
        send_line(800, 1'b0, 1'b0);
        end_frame();
        check("t4_err_end", {28'd0, err_o}, 32'd0);
        check("t4_q_empty", exp_q.size(), 32'd0);

        // Reset in the middle of a line's payload.
        start_frame();
        exp_q.push_back({1'b1, 6'h2B, 16'd800});
        lv_start_i = 1'b1;
        tick(1);
        lv_start_i = 1'b0;
        tick(2);
        byte_en_i = 1'b1;
        tick(300);
        check("t5_pre_hs", {31'd0, hs_en_o}, 32'd1);
        #2;
        reset_n_byte = 1'b0;
        #1;
        check("t5_rst_hs_en", {31'd0, hs_en_o}, 32'd0);
        check("t5_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t5_rst_dt", {26'd0, dt_o}, 32'd0);
        check("t5_rst_wc", {16'd0, wc_o}, 32'd0);
        check("t5_rst_line_cnt", {16'd0, line_cnt_o}, 32'd0);
        byte_en_i = 1'b0;
        exp_fnum  = 16'd1;
        tick(2);
        reset_n_byte = 1'b1;
        tick(2);
        check("t5_q_empty_rst", exp_q.size(), 32'd0);
        start_frame();
        check("t5_line0", {16'd0, line_cnt_o}, 32'd0);
        send_line(800, 1'b0, 1'b0);
        send_line(800, 1'b0, 1'b0);
        end_frame();
        check("t5_err", {28'd0, err_o}, 32'd0);
        check("t5_line_cnt", {16'd0, line_cnt_o}, 32'd2);
        check("t5_q_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
